// File: rtl/byte_serializer_if.sv
// Handshake and serial-output bundle for byte_serializer.
//   data_in    : parallel word from the upstream bit-reverser (producer -> serializer)
//   in_valid   : data_in is valid this cycle (producer -> serializer)
//   in_ready   : serializer accepts a word at the next rising edge (serializer -> producer)
//   sout       : serial data bit
//   sout_valid : sout carries a data bit this cycle
//   sof        : high for exactly the first bit of each word
//   busy       : a word is in flight
// The master modport is the producer/consumer side; the slave modport is the serializer.
interface byte_serializer_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic [WIDTH-1:0] data_in;
  logic             in_valid;
  logic             in_ready;
  logic             sout;
  logic             sout_valid;
  logic             sof;
  logic             busy;

  modport master (
    output data_in,
    output in_valid,
    input  in_ready,
    input  sout,
    input  sout_valid,
    input  sof,
    input  busy
  );

  modport slave (
    input  data_in,
    input  in_valid,
    output in_ready,
    output sout,
    output sout_valid,
    output sof,
    output busy
  );

endinterface

// File: rtl/byte_serializer.sv
// Parallel-to-serial converter for the word produced by the bit-reverser stage.
// A word is accepted through a valid/ready handshake and shifted out one bit per clock.
// Words may follow each other with no idle cycle; sof marks the first bit of each word.
//
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous, active-high reset; aborts any word in flight
//   ser_if : byte_serializer_if.slave (data_in, in_valid, in_ready, sout, sout_valid, sof, busy)
//
// Parameters:
//   WIDTH     : bits per word, 2..32
//   LSB_FIRST : 0 transmits data_in[WIDTH-1] first, 1 transmits data_in[0] first
module byte_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b0
) (
  input logic              clk,
  input logic              rst,
  byte_serializer_if.slave ser_if
);

  localparam int unsigned     CntW   = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q;
  logic             sof_q;
  logic             in_ready_q;
  logic             out_bit;

  // All outputs are held in flops updated alongside the state, so in_ready never depends
  // combinationally on in_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      sof_q      <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (ser_if.in_valid) begin
            state_q    <= StShift;
            shreg_q    <= ser_if.data_in;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            sof_q      <= 1'b1;
            in_ready_q <= 1'b0;
          end
        end
        StShift: begin
          if (cnt_q == CntMax) begin
            if (ser_if.in_valid) begin
              // Seamless reload: the next word's first bit follows the last bit directly.
              shreg_q    <= ser_if.data_in;
              cnt_q      <= '0;
              sof_q      <= 1'b1;
              in_ready_q <= 1'b0;
            end else begin
              state_q    <= StIdle;
              shreg_q    <= '0;
              cnt_q      <= '0;
              busy_q     <= 1'b0;
              sof_q      <= 1'b0;
              in_ready_q <= 1'b1;
            end
          end else begin
            // Shift toward the output end with zero fill.
            shreg_q    <= LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
            cnt_q      <= cnt_q + 1'b1;
            sof_q      <= 1'b0;
            // Ready is raised for the cycle that carries the last bit.
            in_ready_q <= (cnt_q == CntMax - 1'b1);
          end
        end
        default: begin
          state_q    <= StIdle;
          shreg_q    <= '0;
          cnt_q      <= '0;
          busy_q     <= 1'b0;
          sof_q      <= 1'b0;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign out_bit = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];

  // Gating keeps sout at 0 whenever no data bit is being carried.
  assign ser_if.sout       = busy_q & out_bit;
  assign ser_if.sout_valid = busy_q;
  assign ser_if.busy       = busy_q;
  assign ser_if.sof        = sof_q;
  assign ser_if.in_ready   = in_ready_q;

endmodule
